// File: rtl/vga_pkg.sv
// Shared types, 800x600@72 default timing and the test-pattern bar colours
// for the VGA scan-out engine.
package vga_pkg;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgb_t;

  typedef struct packed {
    logic [15:0] h_active, h_fp, h_sync, h_bp;
    logic [15:0] v_active, v_fp, v_sync, v_bp;
    logic        hs_pol, vs_pol;
  } vga_timing_t;

  // Per-pixel control travelling alongside the colour fetch; hs/vs carry pin levels.
  typedef struct packed {
    logic fs, hs, vs, act;
  } ctl_t;

  localparam vga_timing_t VGA_800X600_72 = '{
    h_active: 16'd800, h_fp: 16'd56, h_sync: 16'd120, h_bp: 16'd64,
    v_active: 16'd600, v_fp: 16'd37, v_sync: 16'd6,   v_bp: 16'd23,
    hs_pol: 1'b1, vs_pol: 1'b1};

  function automatic int h_total(vga_timing_t t);
    return int'(t.h_active) + int'(t.h_fp) + int'(t.h_sync) + int'(t.h_bp);
  endfunction

  function automatic int v_total(vga_timing_t t);
    return int'(t.v_active) + int'(t.v_fp) + int'(t.v_sync) + int'(t.v_bp);
  endfunction

  function automatic rgb_t bar_rgb(logic [2:0] idx);
    case (idx)
      3'd0:    return '{b: 8'hFF, g: 8'hFF, r: 8'hFF};
      3'd1:    return '{b: 8'h00, g: 8'hFF, r: 8'hFF};
      3'd2:    return '{b: 8'hFF, g: 8'hFF, r: 8'h00};
      3'd3:    return '{b: 8'h00, g: 8'hFF, r: 8'h00};
      3'd4:    return '{b: 8'hFF, g: 8'h00, r: 8'hFF};
      3'd5:    return '{b: 8'h00, g: 8'h00, r: 8'hFF};
      3'd6:    return '{b: 8'hFF, g: 8'h00, r: 8'h00};
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/vga_display_ctrl_if.sv
// Framebuffer write bus from the CPU store path into the scan-out engine.
interface vga_display_ctrl_if #(
  parameter int AW = 16
);
  logic          fb_we;
  logic [AW-1:0] fb_waddr;
  logic [23:0]   fb_wdata;

  modport master (output fb_we, fb_waddr, fb_wdata);
  modport slave  (input  fb_we, fb_waddr, fb_wdata);
endinterface

// File: rtl/true_dual_port_ram_single_clock.sv
// Single-clock framebuffer RAM: one write port, one read port, read-first.
module true_dual_port_ram_single_clock #(
  parameter int AW = 16,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] q
);
  logic [DW-1:0] mem [2**AW];

  // Same-address collision returns the old word: both sides use NBA.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q <= mem[raddr];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster counters plus raw (unregistered) sync, active and frame strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter vga_timing_t TIMING = VGA_800X600_72,
  parameter int          HW     = 11,
  parameter int          VW     = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  output logic [HW-1:0] h,
  output logic [VW-1:0] v,
  output logic          hs,
  output logic          vs,
  output logic          act,
  output logic          fs
);
  localparam int H_END  = h_total(TIMING) - 1;
  localparam int V_END  = v_total(TIMING) - 1;
  localparam int HS_BEG = int'(TIMING.h_active) + int'(TIMING.h_fp);
  localparam int HS_END = HS_BEG + int'(TIMING.h_sync);
  localparam int VS_BEG = int'(TIMING.v_active) + int'(TIMING.v_fp);
  localparam int VS_END = VS_BEG + int'(TIMING.v_sync);

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (int'(h_q) == H_END) begin
      h_d = '0;
      v_d = (int'(v_q) == V_END) ? '0 : v_q + VW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h   = h_q;
  assign v   = v_q;
  assign hs  = (int'(h_q) >= HS_BEG && int'(h_q) < HS_END) ? TIMING.hs_pol : !TIMING.hs_pol;
  assign vs  = (int'(v_q) >= VS_BEG && int'(v_q) < VS_END) ? TIMING.vs_pol : !TIMING.vs_pol;
  assign act = int'(h_q) < int'(TIMING.h_active) && int'(v_q) < int'(TIMING.v_active);
  assign fs  = (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_display_ctrl.sv
// VGA scan-out: timing gen -> fb address -> RAM -> pins, 3 clks counters to pins.
// Optional colour-bar source enabled by defining VGA_TEST_PATTERN_EN (adds tp_en).
module vga_display_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = 800,
  parameter int H_FP        = 56,
  parameter int H_SYNC      = 120,
  parameter int H_BP        = 64,
  parameter int V_ACTIVE    = 600,
  parameter int V_FP        = 37,
  parameter int V_SYNC      = 6,
  parameter int V_BP        = 23,
  parameter bit HS_POL      = 1'b1,
  parameter bit VS_POL      = 1'b1,
  parameter int SCALE_SHIFT = 2,
  parameter int FB_X_BITS   = 8,
  parameter int FB_Y_BITS   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  vga_display_ctrl_if.slave fb,
`ifdef VGA_TEST_PATTERN_EN
  input  logic              tp_en,
`endif
  output logic              frame_start,
  output logic              vga_clk,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b
);
  localparam vga_timing_t TIM = '{
    h_active: 16'(H_ACTIVE), h_fp: 16'(H_FP), h_sync: 16'(H_SYNC), h_bp: 16'(H_BP),
    v_active: 16'(V_ACTIVE), v_fp: 16'(V_FP), v_sync: 16'(V_SYNC), v_bp: 16'(V_BP),
    hs_pol: HS_POL, vs_pol: VS_POL};
  localparam int   HW       = $clog2(h_total(TIM));
  localparam int   VW       = $clog2(v_total(TIM));
  localparam int   AW       = FB_Y_BITS + FB_X_BITS;
  localparam ctl_t CTL_IDLE = '{fs: 1'b0, hs: !HS_POL, vs: !VS_POL, act: 1'b0};

  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 || SCALE_SHIFT > 4) begin : g_bad_param
    $error("vga_display_ctrl: zero timing parameter or SCALE_SHIFT > 4");
  end

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          hs_raw, vs_raw, act_raw, fs_raw;

  vga_timing_gen #(.TIMING(TIM), .HW(HW), .VW(VW)) u_timing (
    .clk(clk), .reset_n(reset_n), .h(h), .v(v),
    .hs(hs_raw), .vs(vs_raw), .act(act_raw), .fs(fs_raw));

  logic [31:0]   hx, vy;
  logic [AW-1:0] raddr_d, raddr_q;
  logic          s1_oob_d, s1_oob_q, s2_oob_q;
  ctl_t          s1_d, s1_q, s2_d, s2_q, out_d, out_q;
  rgb_t          pix_d, pix_q;
  logic [23:0]   ram_q;

  // Stage 1: fb address and border flag from the scaled raster position.
  always_comb begin
    hx       = 32'(h) >> SCALE_SHIFT;
    vy       = 32'(v) >> SCALE_SHIFT;
    s1_oob_d = ((hx >> FB_X_BITS) != 0) || ((vy >> FB_Y_BITS) != 0);
    raddr_d  = {vy[FB_Y_BITS-1:0], hx[FB_X_BITS-1:0]};
    s1_d     = '{fs: fs_raw, hs: hs_raw, vs: vs_raw, act: act_raw};
    s2_d     = s1_q;
    out_d    = s2_q;
  end

  true_dual_port_ram_single_clock #(.AW(AW), .DW(24)) u_fb (
    .clk(clk), .we(fb.fb_we), .waddr(fb.fb_waddr), .wdata(fb.fb_wdata),
    .raddr(raddr_q), .q(ram_q));

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  rgb_t       tp1_d, tp1_q, tp2_q;
  logic       tpen1_q, tpen2_q;

  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++)
      if (int'(h) >= k * (H_ACTIVE / 8)) bar = 3'(k);
    tp1_d = bar_rgb(bar);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tp1_q   <= '0;
      tp2_q   <= '0;
      tpen1_q <= 1'b0;
      tpen2_q <= 1'b0;
    end else begin
      tp1_q   <= tp1_d;
      tp2_q   <= tp1_q;
      tpen1_q <= tp_en;
      tpen2_q <= tpen1_q;
    end
  end
`endif

  // Stage 2 -> pins: colour gated by the aligned act, border forced black.
  always_comb begin
    pix_d = (s2_q.act && !s2_oob_q) ? rgb_t'(ram_q) : '0;
`ifdef VGA_TEST_PATTERN_EN
    if (tpen2_q) pix_d = s2_q.act ? tp2_q : '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      raddr_q  <= '0;
      s1_oob_q <= 1'b0;
      s2_oob_q <= 1'b0;
      s1_q     <= CTL_IDLE;
      s2_q     <= CTL_IDLE;
      out_q    <= CTL_IDLE;
      pix_q    <= '0;
    end else begin
      raddr_q  <= raddr_d;
      s1_oob_q <= s1_oob_d;
      s2_oob_q <= s1_oob_q;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      out_q    <= out_d;
      pix_q    <= pix_d;
    end
  end

  assign vga_clk     = clk;
  assign frame_start = out_q.fs;
  assign vga_hs      = out_q.hs;
  assign vga_vs      = out_q.vs;
  assign vga_blank_n = out_q.act;
  assign vga_r       = pix_q.r;
  assign vga_g       = pix_q.g;
  assign vga_b       = pix_q.b;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Directed bench for vga_display_ctrl on a shrunken 24x16 raster.
`timescale 1ns/1ps
module tb_vga_display_ctrl;
  localparam int HT = 24;       // 16 + 2 + 3 + 3
  localparam int VT = 16;       // 12 + 1 + 2 + 1
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       frame_start, vga_clk, vga_hs, vga_vs, vga_blank_n;
  logic [7:0] vga_r, vga_g, vga_b;
`ifdef VGA_TEST_PATTERN_EN
  logic       tp_en;
`endif

  vga_display_ctrl_if #(.AW(3)) fb_if ();

  vga_display_ctrl #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .SCALE_SHIFT(2), .FB_X_BITS(1), .FB_Y_BITS(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .fb(fb_if),
`ifdef VGA_TEST_PATTERN_EN
    .tp_en(tp_en),
`endif
    .frame_start(frame_start), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b));

  always #5 clk = ~clk;

  int n, n_vec, n_err;
  logic [23:0] init_rgb [8] = '{24'h0000FF, 24'h00FF00, 24'hFF0000, 24'h123456,
                                24'hABCDEF, 24'h010203, 24'h777777, 24'h888888};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    @(negedge clk);
  endtask

  task automatic wait_n(input int target);
    if (n > target) chk("sequence_late", n, target);
    while (n < target) tick();
  endtask

  // Pins after posedge n show the raster position the counters held at n-3.
  task automatic pix(input int f, input int v, input int h);
    wait_n(f * FT + v * HT + h + 3);
  endtask

  function automatic logic [23:0] rgb();
    return {vga_b, vga_g, vga_r};
  endfunction

  initial begin
    int fs_cnt, hs_rise, hs_hi, vs_lo, bl_hi, r0, r1;
    logic prev_hs;
    n = 0; n_vec = 0; n_err = 0;
    reset_n = 1'b0;
    fb_if.fb_we = 1'b0; fb_if.fb_waddr = '0; fb_if.fb_wdata = '0;
`ifdef VGA_TEST_PATTERN_EN
    tp_en = 1'b0;
`endif
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      fb_if.fb_we = 1'b1; fb_if.fb_waddr = 3'(a); fb_if.fb_wdata = init_rgb[a];
      tick();
    end
    fb_if.fb_we = 1'b0;
    tick();
    chk("rst_hs", vga_hs, 1'b0);
    chk("rst_vs", vga_vs, 1'b1);
    chk("rst_blank_n", vga_blank_n, 1'b0);
    chk("rst_rgb", rgb(), 24'h0);
    chk("rst_fs", frame_start, 1'b0);
    chk("vga_clk", vga_clk, 1'b0);

    reset_n = 1'b1; n = 0;
    tick(); chk("fs_n1", frame_start, 1'b0);
    tick(); chk("fs_n2", frame_start, 1'b0);
    tick(); chk("fs_n3", frame_start, 1'b1);
    chk("pix_0_0", rgb(), 24'h0000FF);
    chk("blank_0_0", vga_blank_n, 1'b1);

    pix(0, 0, 1);  chk("fs_only_origin", frame_start, 1'b0);
    pix(0, 0, 4);  chk("pix_4_0", rgb(), 24'h00FF00);
    pix(0, 0, 8);  chk("border_8_0", rgb(), 24'h0);
    chk("border_blank_8_0", vga_blank_n, 1'b1);
    pix(0, 0, 16); chk("hblank_16", vga_blank_n, 1'b0);
    chk("hblank_rgb_16", rgb(), 24'h0);
    pix(0, 0, 17); chk("hs_17", vga_hs, 1'b0);
    pix(0, 0, 18); chk("hs_18", vga_hs, 1'b1);
    pix(0, 0, 20); chk("hs_20", vga_hs, 1'b1);
    pix(0, 0, 21); chk("hs_21", vga_hs, 1'b0);
    pix(0, 3, 3);  chk("pix_3_3", rgb(), 24'h0000FF);
    pix(0, 3, 7);  chk("pix_7_3", rgb(), 24'h00FF00);
    pix(0, 4, 0);  chk("pix_0_4", rgb(), 24'hFF0000);
    pix(0, 9, 5);  chk("pix_5_9", rgb(), 24'h010203);
    pix(0, 11, 15); chk("border_15_11", rgb(), 24'h0);
    chk("border_blank_15_11", vga_blank_n, 1'b1);
    pix(0, 12, 0); chk("vs_12", vga_vs, 1'b1);
    chk("vblank_12", vga_blank_n, 1'b0);
    pix(0, 13, 0); chk("vs_13", vga_vs, 1'b0);
    pix(0, 14, 23); chk("vs_14_end", vga_vs, 1'b0);
    pix(0, 15, 23); chk("vs_15", vga_vs, 1'b1);

    // One full frame of pin statistics.
    prev_hs = vga_hs;
    fs_cnt = 0; hs_rise = 0; hs_hi = 0; vs_lo = 0; bl_hi = 0; r0 = -1; r1 = -1;
    for (int i = 0; i < FT; i++) begin
      tick();
      fs_cnt += int'(frame_start);
      hs_hi  += int'(vga_hs);
      vs_lo  += int'(!vga_vs);
      bl_hi  += int'(vga_blank_n);
      if (vga_hs && !prev_hs) begin
        hs_rise++;
        if (r0 < 0) r0 = n; else if (r1 < 0) r1 = n;
      end
      prev_hs = vga_hs;
    end
    chk("frame_fs_count", fs_cnt, 1);
    chk("frame_hs_rises", hs_rise, VT);
    chk("hs_period", r1 - r0, HT);
    chk("hs_high_cycles", hs_hi, 3 * VT);
    chk("vs_low_cycles", vs_lo, 2 * HT);
    chk("blank_n_cycles", bl_hi, 16 * 12);

    // Write addr {y=1,x=1} on the very edge that reads it for pixel (7,4).
    wait_n(2 * FT + 4 * HT + 7 + 1);
    fb_if.fb_we = 1'b1; fb_if.fb_waddr = 3'd3; fb_if.fb_wdata = 24'h654321;
    tick();
    fb_if.fb_we = 1'b0;
    pix(2, 4, 7); chk("collide_old", rgb(), 24'h123456);
    pix(2, 5, 4); chk("after_write", rgb(), 24'h654321);
    pix(3, 4, 7); chk("collide_next_frame", rgb(), 24'h654321);

    // One-clock reset mid-line at raster (10,6).
    wait_n(4 * FT + 6 * HT + 10);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_hs", vga_hs, 1'b0);
    chk("mid_rst_vs", vga_vs, 1'b1);
    chk("mid_rst_blank_n", vga_blank_n, 1'b0);
    chk("mid_rst_rgb", rgb(), 24'h0);
    chk("mid_rst_fs", frame_start, 1'b0);
    reset_n = 1'b1; n = 0;
    tick(); chk("rel_fs_n1", frame_start, 1'b0);
    tick(); chk("rel_fs_n2", frame_start, 1'b0);
    chk("rel_flush_blank_n2", vga_blank_n, 1'b0);
    tick(); chk("rel_fs_n3", frame_start, 1'b1);
    chk("rel_pix_0_0", rgb(), 24'h0000FF);

`ifdef VGA_TEST_PATTERN_EN
    tp_en = 1'b1;
    pix(0, 1, 0);  chk("tp_white", rgb(), 24'hFFFFFF);
    pix(0, 1, 2);  chk("tp_yellow", rgb(), 24'h00FFFF);
    pix(0, 1, 8);  chk("tp_magenta", rgb(), 24'hFF00FF);
    pix(0, 1, 15); chk("tp_black", rgb(), 24'h000000);
    chk("tp_blank_n", vga_blank_n, 1'b1);
    pix(0, 1, 16); chk("tp_hblank_rgb", rgb(), 24'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
